// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile: Y86 write-back stage.
//
// This module holds the W pipeline register and commits valE/valM into a
// 15-entry register file. It also provides two combinational decode read
// ports, keeps the sticky processor status, and counts retired instructions.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, a read whose address matches a destination of the
//   instruction committing in this cycle returns the committing value.
//   The dstM match takes priority over the dstE match.
//   When undefined, reads return the array contents only.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   m_valid..m_dstM     memory-stage results presented for capture
//   w_stall, w_bubble   W register hold / NOP insert (bubble wins)
//   rd_srcA/B -> rd_valA/B   decode read ports (ID 4'hF reads 0)
//   w_valid..w_dstM     W register contents
//   cpu_stat, halted    sticky status (AOK=1) and cpu_stat != AOK
//   retire_cnt          retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m_valid,
   input  logic [3:0]        m_icode,
   input  logic [3:0]        m_stat,
   input  logic [DATA_W-1:0] m_valE,
   input  logic [DATA_W-1:0] m_valM,
   input  logic [3:0]        m_dstE,
   input  logic [3:0]        m_dstM,
   input  logic              w_stall,
   input  logic              w_bubble,
   input  logic [3:0]        rd_srcA,
   input  logic [3:0]        rd_srcB,
   output logic [DATA_W-1:0] rd_valA,
   output logic [DATA_W-1:0] rd_valB,
   output logic              w_valid,
   output logic [3:0]        w_icode,
   output logic [3:0]        w_stat,
   output logic [DATA_W-1:0] w_valE,
   output logic [DATA_W-1:0] w_valM,
   output logic [3:0]        w_dstE,
   output logic [3:0]        w_dstM,
   output logic [3:0]        cpu_stat,
   output logic              halted,
   output logic [CNT_W-1:0]  retire_cnt
);

   localparam logic [3:0] STAT_AOK  = 4'h1;
   localparam logic [3:0] ICODE_NOP = 4'h1;
   localparam logic [3:0] REG_NONE  = 4'hF;

   logic              w_valid_q,  w_valid_d;
   logic [3:0]        w_icode_q,  w_icode_d;
   logic [3:0]        w_stat_q,   w_stat_d;
   logic [DATA_W-1:0] w_valE_q,   w_valE_d;
   logic [DATA_W-1:0] w_valM_q,   w_valM_d;
   logic [3:0]        w_dstE_q,   w_dstE_d;
   logic [3:0]        w_dstM_q,   w_dstM_d;
   logic              w_fresh_q,  w_fresh_d;
   logic [3:0]        cpu_stat_q, cpu_stat_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic [DATA_W-1:0] regs_q [0:14];
   logic [DATA_W-1:0] regs_d [0:14];

   logic halted_w;
   logic commit;
   logic fault;

   assign halted_w = (cpu_stat_q != STAT_AOK);

   // w_fresh marks the first cycle an entry sits in W. A stalled entry
   // therefore commits (or faults) only once.
   assign commit = w_fresh_q & w_valid_q & (w_stat_q == STAT_AOK) & ~halted_w;
   assign fault  = w_fresh_q & w_valid_q & (w_stat_q != STAT_AOK) & ~halted_w;

   always_comb begin
      w_valid_d    = w_valid_q;
      w_icode_d    = w_icode_q;
      w_stat_d     = w_stat_q;
      w_valE_d     = w_valE_q;
      w_valM_d     = w_valM_q;
      w_dstE_d     = w_dstE_q;
      w_dstM_d     = w_dstM_q;
      w_fresh_d    = 1'b0;
      cpu_stat_d   = cpu_stat_q;
      retire_cnt_d = retire_cnt_q;
      regs_d       = regs_q;

      if (w_bubble) begin
         w_valid_d = 1'b0;
         w_icode_d = ICODE_NOP;
         w_stat_d  = STAT_AOK;
         w_valE_d  = '0;
         w_valM_d  = '0;
         w_dstE_d  = REG_NONE;
         w_dstM_d  = REG_NONE;
      end else if (!w_stall) begin
         w_valid_d = m_valid;
         w_icode_d = m_icode;
         w_stat_d  = m_stat;
         w_valE_d  = m_valE;
         w_valM_d  = m_valM;
         w_dstE_d  = m_dstE;
         w_dstM_d  = m_dstM;
         w_fresh_d = m_valid;
      end

      // The valM write comes second so that it wins when both IDs match.
      if (commit) begin
         if (w_dstE_q != REG_NONE) regs_d[w_dstE_q] = w_valE_q;
         if (w_dstM_q != REG_NONE) regs_d[w_dstM_q] = w_valM_q;
         retire_cnt_d = retire_cnt_q + 1'b1;
      end

      if (fault) cpu_stat_d = w_stat_q;
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [3:0] src);
      logic [DATA_W-1:0] val;
      val = '0;
      if (src != REG_NONE) begin
         val = regs_q[src];
`ifdef WB_BYPASS_EN
         if (commit && src == w_dstM_q)      val = w_valM_q;
         else if (commit && src == w_dstE_q) val = w_valE_q;
`endif
      end
      return val;
   endfunction

   always_comb begin
      rd_valA = read_port(rd_srcA);
      rd_valB = read_port(rd_srcB);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_valid_q    <= 1'b0;
         w_icode_q    <= ICODE_NOP;
         w_stat_q     <= STAT_AOK;
         w_valE_q     <= '0;
         w_valM_q     <= '0;
         w_dstE_q     <= REG_NONE;
         w_dstM_q     <= REG_NONE;
         w_fresh_q    <= 1'b0;
         cpu_stat_q   <= STAT_AOK;
         retire_cnt_q <= '0;
         for (int i = 0; i < 15; i++) regs_q[i] <= '0;
      end else begin
         w_valid_q    <= w_valid_d;
         w_icode_q    <= w_icode_d;
         w_stat_q     <= w_stat_d;
         w_valE_q     <= w_valE_d;
         w_valM_q     <= w_valM_d;
         w_dstE_q     <= w_dstE_d;
         w_dstM_q     <= w_dstM_d;
         w_fresh_q    <= w_fresh_d;
         cpu_stat_q   <= cpu_stat_d;
         retire_cnt_q <= retire_cnt_d;
         regs_q       <= regs_d;
      end
   end

   assign w_valid    = w_valid_q;
   assign w_icode    = w_icode_q;
   assign w_stat     = w_stat_q;
   assign w_valE     = w_valE_q;
   assign w_valM     = w_valM_q;
   assign w_dstE     = w_dstE_q;
   assign w_dstM     = w_dstM_q;
   assign cpu_stat   = cpu_stat_q;
   assign halted     = halted_w;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage for the Y86 pipeline, directly downstream of the memory stage. It latches the memory-stage results into the W pipeline register and commits `valE`/`valM` to a 15-entry register file. It also provides two combinational read ports to decode, keeps the sticky processor status, and counts retired instructions.

## Interface
- `DATA_W`, 32: register and data width.
- `CNT_W`, 32: retired-instruction counter width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `m_valid` input 1: memory stage presents an instruction.
- `m_icode` input 4: instruction code.
- `m_stat` input 4: stage status; AOK=1, HLT=2, ADR=3, INS=4.
- `m_valE` input DATA_W: ALU result.
- `m_valM` input DATA_W: memory read data.
- `m_dstE`, `m_dstM` input 4: destination register IDs; 4'hF means none.
- `w_stall` input 1: hold the W register.
- `w_bubble` input 1: insert a NOP into W.
- `rd_srcA`, `rd_srcB` input 4: decode read addresses.
- `rd_valA`, `rd_valB` output DATA_W: read data.
- `w_valid`, `w_icode`, `w_stat`, `w_valE`, `w_valM`, `w_dstE`, `w_dstM` output: W register contents.
- `cpu_stat` output 4: sticky processor status.
- `halted` output 1: `cpu_stat != AOK`.
- `retire_cnt` output CNT_W: retired-instruction count.

## Operation
- W register priority, highest first: `rst`, then `w_bubble`, then `w_stall`, then capture.
  - `rst` and `w_bubble` load the NOP state: `w_valid`=0, `w_icode`=4'h1, `w_stat`=AOK, `w_dstE`=`w_dstM`=4'hF, `w_valE`=`w_valM`=0.
  - `w_stall` holds every field.
  - Capture loads all `m_*` fields.
- Internal `w_fresh` flag:
  - Set to 1 on a capture with `m_valid`=1.
  - Cleared to 0 on any other edge: stall, bubble, `rst`, or a capture with `m_valid`=0.
  - A stalled entry therefore commits exactly once.
- Commit condition: `w_fresh & w_valid & (w_stat==AOK) & ~halted`.
- Commit actions, taken at the edge ending the commit cycle:
  - Write `w_valE` to `regs[w_dstE]` if `w_dstE != F`.
  - Write `w_valM` to `regs[w_dstM]` if `w_dstM != F`.
  - If both IDs name the same register, `w_valM` wins.
  - Increment `retire_cnt`.
- Status tracking:
  - `cpu_stat` resets to AOK.
  - When `w_fresh & w_valid & (w_stat != AOK) & ~halted`, `cpu_stat` loads `w_stat`.
  - The faulting instruction does not write the register file and does not count.
  - `cpu_stat` holds until `rst`; all later commits are suppressed.
- Read ports:
  - `rd_srcX == F` returns 0.
  - Otherwise returns `regs[rd_srcX]`.
  - Bypass behaviour is set under Configuration.
- Registers 0–14 reset to 0. `retire_cnt` resets to 0 and wraps modulo 2^CNT_W.

## Timing
- Memory-stage outputs are captured at edge N and visible on the `w_*` outputs after edge N.
- The register-file write and counter increment happen at edge N+1.
- Without bypass, the new value is readable on `rd_val*` after edge N+1.
- `halted` asserts after the edge that ends a fresh non-AOK W cycle.
- `rst` asserted mid-operation clears a pending commit: `w_fresh` is forced to 0, and no write occurs on the reset edge.
- `w_bubble` together with `w_stall` behaves as bubble.
- A stall held for many cycles produces no repeated writes or counts.

## Configuration
- `WB_BYPASS_EN` defined:
  - During a commit cycle, a read whose `rd_srcX` matches `w_dstM` returns `w_valM`.
  - Otherwise, a match on `w_dstE` returns `w_valE`.
  - Otherwise the read returns the array value.
  - Reads then see a same-cycle write combinationally.
- `WB_BYPASS_EN` undefined: reads return array contents only, one cycle later than with bypass.

## Test plan
- `rst` for 2 cycles → all `w_*` at NOP values, `cpu_stat`=1, `halted`=0, `retire_cnt`=0, `rd_valA` of reg 3 = 0.
- Capture `m_valid`=1, `m_stat`=1, `m_dstE`=3, `m_valE`=32'h55, `m_dstM`=F, then present bubbles → reg 3 = 32'h55 after the second edge, `retire_cnt`=1.
- Capture `m_dstE`=4, `m_valE`=32'h10, `m_dstM`=4, `m_valM`=32'h99 (popl %rsp) → reg 4 = 32'h99.
- Capture a valid entry, then hold `w_stall`=1 for 5 cycles → exactly one write, `retire_cnt` increments by 1.
- Capture `m_stat`=2 (HLT) with `m_dstE`=5, `m_valE`=32'h77, followed by valid AOK writes to reg 6 → reg 5 and reg 6 unchanged, `cpu_stat`=2, `halted`=1, `retire_cnt` frozen until `rst`.
- With `WB_BYPASS_EN` defined: set `rd_srcA`=7 during the commit cycle of `m_dstE`=7, `m_valE`=32'hAB → `rd_valA`=32'hAB in that same cycle. With the macro undefined → `rd_valA` shows the old value, then 32'hAB after the edge.
